// File: rtl/hazard_control_if.sv
// hazard_control_if: pipeline-side hazard inputs and the control/forwarding outputs of the hazard unit.
interface hazard_control_if #(parameter int CNT_W = 16);
  logic [4:0] RsD, RtD, RsE, RtE;
  logic [4:0] WriteRegE, WriteRegM, WriteRegW;
  logic RegWriteE, RegWriteM, RegWriteW;
  logic LoadE, MemtoRegM, BranchD, PCSrcD, StopD;
  logic EnableF, EnableD, EnableE, RstD, RstE;
  logic [1:0] ForwardAE, ForwardBE;
  logic ForwardAD, ForwardBD, Halted;
  logic [CNT_W-1:0] StallCount, FlushCount;
  modport master (
    input RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW,
    input RegWriteE, RegWriteM, RegWriteW, LoadE, MemtoRegM, BranchD, PCSrcD, StopD,
    output EnableF, EnableD, EnableE, RstD, RstE,
    output ForwardAE, ForwardBE, ForwardAD, ForwardBD, Halted, StallCount, FlushCount
  );
  modport slave (
    output RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW,
    output RegWriteE, RegWriteM, RegWriteW, LoadE, MemtoRegM, BranchD, PCSrcD, StopD,
    input EnableF, EnableD, EnableE, RstD, RstE,
    input ForwardAE, ForwardBE, ForwardAD, ForwardBD, Halted, StallCount, FlushCount
  );
endinterface

// File: rtl/hazard_control.sv
// hazard_control: stall/flush/forward control for the 5-stage pipeline plus stop-instruction drain sequencing.
module hazard_control #(parameter int CNT_W = 16) (
  input logic CLK,
  input logic RstN,
  hazard_control_if.master hc
);
  typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;
  state_t state, state_nxt;
  logic [1:0] cnt, cnt_nxt;
  logic e_hit, m_hit, stall_d, flush_d;
  logic en_f, en_e, rst_d, rst_e, halted;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
  function automatic logic hit(input logic we, input logic [4:0] wr, input logic [4:0] r);
    return we && (wr != 5'd0) && (wr == r);
  endfunction
  always_comb begin
    e_hit = hit(hc.RegWriteE, hc.WriteRegE, hc.RsD) | hit(hc.RegWriteE, hc.WriteRegE, hc.RtD);
    m_hit = hit(hc.RegWriteM, hc.WriteRegM, hc.RsD) | hit(hc.RegWriteM, hc.WriteRegM, hc.RtD);
    stall_d = (hc.LoadE & e_hit) | (hc.BranchD & (e_hit | (hc.MemtoRegM & m_hit)));
    flush_d = hc.PCSrcD & ~stall_d;
  end
  always_comb begin
    state_nxt = state;
    cnt_nxt = cnt;
    en_f = 1'b0;
    en_e = 1'b0;
    rst_d = 1'b0;
    rst_e = 1'b0;
    halted = 1'b0;
    case (state)
      RUN: begin
        en_f = ~stall_d;
        en_e = 1'b1;
        rst_e = stall_d;
        rst_d = flush_d;
        if (hc.StopD && !stall_d) begin
          state_nxt = DRAIN;
          cnt_nxt = 2'd3;
        end
      end
      DRAIN: begin
        en_e = 1'b1;
        rst_e = 1'b1;
        cnt_nxt = cnt - 2'd1;
        state_nxt = (cnt == 2'd1) ? HALTED : DRAIN;
      end
      default: halted = 1'b1;
    endcase
  end
  always_ff @(posedge CLK or negedge RstN)
    if (!RstN) begin
      state <= RUN;
      cnt <= 2'd0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      state <= state_nxt;
      cnt <= cnt_nxt;
      if (state == RUN && stall_d && !(&stall_cnt)) stall_cnt <= stall_cnt + CNT_W'(1);
      if (state == RUN && flush_d && !(&flush_cnt)) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  // reset overrides every control output combinationally, independent of the FSM
  assign hc.EnableF = RstN & en_f;
  assign hc.EnableD = RstN & en_f;
  assign hc.EnableE = RstN & en_e;
  assign hc.RstD = ~RstN | rst_d;
  assign hc.RstE = ~RstN | rst_e;
  assign hc.Halted = RstN & halted;
  assign hc.ForwardAE = !RstN ? 2'b00 : hit(hc.RegWriteM, hc.WriteRegM, hc.RsE) ? 2'b10 :
                        hit(hc.RegWriteW, hc.WriteRegW, hc.RsE) ? 2'b01 : 2'b00;
  assign hc.ForwardBE = !RstN ? 2'b00 : hit(hc.RegWriteM, hc.WriteRegM, hc.RtE) ? 2'b10 :
                        hit(hc.RegWriteW, hc.WriteRegW, hc.RtE) ? 2'b01 : 2'b00;
  assign hc.ForwardAD = RstN & hit(hc.RegWriteM, hc.WriteRegM, hc.RsD);
  assign hc.ForwardBD = RstN & hit(hc.RegWriteM, hc.WriteRegM, hc.RtD);
  assign hc.StallCount = stall_cnt;
  assign hc.FlushCount = flush_cnt;
endmodule

// File: tb/tb_hazard_control.sv
// tb_hazard_control: directed-vector bench for hazard_control; ctl packs {EnableF,EnableD,EnableE,RstD,RstE,Halted}.
module tb_hazard_control;
  logic CLK = 1'b0;
  logic RstN;
  int nvec = 0;
  int nerr = 0;
  logic [5:0] ctl;
  always #5 CLK = ~CLK;
  hazard_control_if #(.CNT_W(16)) hi();
  hazard_control_if #(.CNT_W(2)) hs();
  hazard_control #(.CNT_W(16)) dut (.CLK(CLK), .RstN(RstN), .hc(hi));
  hazard_control #(.CNT_W(2)) dut_s (.CLK(CLK), .RstN(RstN), .hc(hs));
  assign ctl = {hi.EnableF, hi.EnableD, hi.EnableE, hi.RstD, hi.RstE, hi.Halted};
  task automatic clear_in();
    {hi.RsD, hi.RtD, hi.RsE, hi.RtE, hi.WriteRegE, hi.WriteRegM, hi.WriteRegW} = '0;
    {hi.RegWriteE, hi.RegWriteM, hi.RegWriteW, hi.LoadE, hi.MemtoRegM, hi.BranchD, hi.PCSrcD, hi.StopD} = '0;
    {hs.RsD, hs.RtD, hs.RsE, hs.RtE, hs.WriteRegE, hs.WriteRegM, hs.WriteRegW} = '0;
    {hs.RegWriteE, hs.RegWriteM, hs.RegWriteW, hs.LoadE, hs.MemtoRegM, hs.BranchD, hs.PCSrcD, hs.StopD} = '0;
  endtask
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask
  task automatic test_reset();
    clear_in();
    RstN = 1'b0;
    hi.LoadE = 1'b1; hi.RegWriteE = 1'b1; hi.WriteRegE = 5'd8; hi.RsD = 5'd8;
    hi.RegWriteM = 1'b1; hi.WriteRegM = 5'd5; hi.RsE = 5'd5; hi.PCSrcD = 1'b1;
    #2;
    nvec++; if (ctl !== 6'b000110) begin nerr++; $display("FAIL reset_ctl got %b want %b", ctl, 6'b000110); end
    nvec++; if (hi.ForwardAE !== 2'b00) begin nerr++; $display("FAIL reset_fwdae got %b want 00", hi.ForwardAE); end
    tick(); tick();
    nvec++; if (hi.StallCount !== 16'd0) begin nerr++; $display("FAIL reset_stallcnt got %0d want 0", hi.StallCount); end
    RstN = 1'b1;
    clear_in();
    #2;
    nvec++; if (ctl !== 6'b111000) begin nerr++; $display("FAIL reset_release_ctl got %b want %b", ctl, 6'b111000); end
  endtask
  task automatic test_forward();
    clear_in();
    hi.RegWriteM = 1'b1; hi.RegWriteW = 1'b1; hi.WriteRegM = 5'd5; hi.WriteRegW = 5'd5; hi.RsE = 5'd5; hi.RtE = 5'd7;
    #2;
    nvec++; if (hi.ForwardAE !== 2'b10) begin nerr++; $display("FAIL fwd_mem_prio got %b want 10", hi.ForwardAE); end
    nvec++; if (hi.ForwardBE !== 2'b00) begin nerr++; $display("FAIL fwd_be_none got %b want 00", hi.ForwardBE); end
    hi.WriteRegM = 5'd0;
    #2;
    nvec++; if (hi.ForwardAE !== 2'b01) begin nerr++; $display("FAIL fwd_wb got %b want 01", hi.ForwardAE); end
    hi.WriteRegW = 5'd0; hi.RsE = 5'd0;
    #2;
    nvec++; if (hi.ForwardAE !== 2'b00) begin nerr++; $display("FAIL fwd_r0 got %b want 00", hi.ForwardAE); end
    hi.RegWriteM = 1'b0; hi.WriteRegM = 5'd6; hi.WriteRegW = 5'd6; hi.RtE = 5'd6;
    #2;
    nvec++; if (hi.ForwardBE !== 2'b01) begin nerr++; $display("FAIL fwd_be_nowrite_m got %b want 01", hi.ForwardBE); end
    hi.RegWriteM = 1'b1; hi.WriteRegM = 5'd3; hi.RsD = 5'd3; hi.RtD = 5'd4;
    #2;
    nvec++; if ({hi.ForwardAD, hi.ForwardBD} !== 2'b10) begin nerr++; $display("FAIL fwd_id_a got %b want 10", {hi.ForwardAD, hi.ForwardBD}); end
    hi.RtD = 5'd3;
    #2;
    nvec++; if ({hi.ForwardAD, hi.ForwardBD, ctl} !== 8'b11_111000) begin nerr++; $display("FAIL fwd_id_b got %b want %b", {hi.ForwardAD, hi.ForwardBD, ctl}, 8'b11_111000); end
  endtask
  task automatic test_load_use();
    tick(); clear_in();
    hi.LoadE = 1'b1; hi.RegWriteE = 1'b1; hi.WriteRegE = 5'd0; hi.RsD = 5'd0;
    #2;
    nvec++; if (ctl !== 6'b111000) begin nerr++; $display("FAIL ld_r0_ctl got %b want %b", ctl, 6'b111000); end
    hi.WriteRegE = 5'd8; hi.RsD = 5'd8;
    #2;
    nvec++; if (ctl !== 6'b001010) begin nerr++; $display("FAIL ld_stall_ctl got %b want %b", ctl, 6'b001010); end
    nvec++; if (hi.StallCount !== 16'd0) begin nerr++; $display("FAIL ld_cnt0 got %0d want 0", hi.StallCount); end
    tick();
    hi.LoadE = 1'b0; hi.RegWriteE = 1'b0; hi.WriteRegE = 5'd0;
    hi.RegWriteM = 1'b1; hi.WriteRegM = 5'd8; hi.MemtoRegM = 1'b1;
    #2;
    nvec++; if (ctl !== 6'b111000) begin nerr++; $display("FAIL ld_after_ctl got %b want %b", ctl, 6'b111000); end
    nvec++; if (hi.StallCount !== 16'd1) begin nerr++; $display("FAIL ld_cnt1 got %0d want 1", hi.StallCount); end
  endtask
  task automatic test_branch_load();
    tick(); clear_in();
    hi.BranchD = 1'b1; hi.PCSrcD = 1'b1; hi.LoadE = 1'b1; hi.RegWriteE = 1'b1; hi.WriteRegE = 5'd9; hi.RtD = 5'd9;
    #2;
    nvec++; if (ctl !== 6'b001010) begin nerr++; $display("FAIL br_stall1 got %b want %b", ctl, 6'b001010); end
    tick();
    hi.LoadE = 1'b0; hi.RegWriteE = 1'b0; hi.WriteRegE = 5'd0;
    hi.RegWriteM = 1'b1; hi.WriteRegM = 5'd9; hi.MemtoRegM = 1'b1;
    #2;
    nvec++; if (ctl !== 6'b001010) begin nerr++; $display("FAIL br_stall2 got %b want %b", ctl, 6'b001010); end
    nvec++; if (hi.FlushCount !== 16'd0) begin nerr++; $display("FAIL br_flush0 got %0d want 0", hi.FlushCount); end
    tick();
    hi.RegWriteM = 1'b0; hi.WriteRegM = 5'd0; hi.MemtoRegM = 1'b0; hi.RegWriteW = 1'b1; hi.WriteRegW = 5'd9;
    #2;
    nvec++; if (ctl !== 6'b111100) begin nerr++; $display("FAIL br_flush_ctl got %b want %b", ctl, 6'b111100); end
    nvec++; if (hi.StallCount !== 16'd3) begin nerr++; $display("FAIL br_stallcnt got %0d want 3", hi.StallCount); end
    tick(); clear_in();
    #2;
    nvec++; if (hi.FlushCount !== 16'd1) begin nerr++; $display("FAIL br_flush1 got %0d want 1", hi.FlushCount); end
  endtask
  task automatic test_stop_blocked_and_reset();
    tick(); clear_in();
    hi.StopD = 1'b1; hi.LoadE = 1'b1; hi.RegWriteE = 1'b1; hi.WriteRegE = 5'd4; hi.RsD = 5'd4;
    #2;
    nvec++; if (ctl !== 6'b001010) begin nerr++; $display("FAIL stop_blk_ctl got %b want %b", ctl, 6'b001010); end
    tick();
    hi.LoadE = 1'b0; hi.RegWriteE = 1'b0;
    #2;
    nvec++; if (ctl !== 6'b111000) begin nerr++; $display("FAIL stop_go_ctl got %b want %b", ctl, 6'b111000); end
    tick();
    hi.LoadE = 1'b1; hi.RegWriteE = 1'b1; hi.PCSrcD = 1'b1;
    hi.RegWriteM = 1'b1; hi.WriteRegM = 5'd5; hi.RsE = 5'd5;
    #2;
    nvec++; if (ctl !== 6'b001010) begin nerr++; $display("FAIL drain1_ctl got %b want %b", ctl, 6'b001010); end
    tick();
    #1;
    nvec++; if ({hi.StallCount, hi.FlushCount} !== {16'd4, 16'd1}) begin nerr++; $display("FAIL drain_cnts got %0d/%0d want 4/1", hi.StallCount, hi.FlushCount); end
    nvec++; if (ctl !== 6'b001010) begin nerr++; $display("FAIL drain2_ctl got %b want %b", ctl, 6'b001010); end
    RstN = 1'b0;
    #2;
    nvec++; if ({ctl, hi.ForwardAE} !== 8'b000110_00) begin nerr++; $display("FAIL drain_rst_ctl got %b want %b", {ctl, hi.ForwardAE}, 8'b000110_00); end
    nvec++; if ({hi.StallCount, hi.FlushCount} !== 32'd0) begin nerr++; $display("FAIL drain_rst_cnts got %0d/%0d want 0/0", hi.StallCount, hi.FlushCount); end
    tick(); tick();
    RstN = 1'b1; clear_in();
    #2;
    nvec++; if (ctl !== 6'b111000) begin nerr++; $display("FAIL post_rst_ctl got %b want %b", ctl, 6'b111000); end
    repeat (4) tick();
    nvec++; if (ctl !== 6'b111000) begin nerr++; $display("FAIL post_rst_run got %b want %b", ctl, 6'b111000); end
  endtask
  task automatic test_halt();
    tick(); clear_in();
    hi.StopD = 1'b1;
    #2;
    nvec++; if (ctl !== 6'b111000) begin nerr++; $display("FAIL halt_stop_ctl got %b want %b", ctl, 6'b111000); end
    for (int i = 1; i <= 3; i++) begin
      tick();
      nvec++; if (ctl !== 6'b001010) begin nerr++; $display("FAIL halt_drain%0d got %b want %b", i, ctl, 6'b001010); end
    end
    tick();
    nvec++; if (ctl !== 6'b000001) begin nerr++; $display("FAIL halt_enter got %b want %b", ctl, 6'b000001); end
    hi.LoadE = 1'b1; hi.RegWriteE = 1'b1; hi.WriteRegE = 5'd3; hi.RsD = 5'd3; hi.PCSrcD = 1'b1;
    for (int i = 0; i < 4; i++) begin
      hi.StopD = i[0];
      tick();
      nvec++; if (ctl !== 6'b000001) begin nerr++; $display("FAIL halt_hold%0d got %b want %b", i, ctl, 6'b000001); end
    end
    hi.RegWriteM = 1'b1; hi.WriteRegM = 5'd5; hi.RsE = 5'd5;
    #2;
    nvec++; if (hi.ForwardAE !== 2'b10) begin nerr++; $display("FAIL halt_fwd got %b want 10", hi.ForwardAE); end
    nvec++; if ({hi.StallCount, hi.FlushCount} !== 32'd0) begin nerr++; $display("FAIL halt_cnts got %0d/%0d want 0/0", hi.StallCount, hi.FlushCount); end
    RstN = 1'b0; tick(); RstN = 1'b1; clear_in();
    #2;
    nvec++; if (ctl !== 6'b111000) begin nerr++; $display("FAIL halt_exit got %b want %b", ctl, 6'b111000); end
  endtask
  task automatic test_saturation();
    tick(); clear_in();
    hs.LoadE = 1'b1; hs.RegWriteE = 1'b1; hs.WriteRegE = 5'd2; hs.RsD = 5'd2;
    for (int i = 0; i < 5; i++) begin
      tick();
      nvec++; if (hs.StallCount !== 2'(i < 3 ? i + 1 : 3)) begin nerr++; $display("FAIL sat_stall%0d got %0d want %0d", i, hs.StallCount, i < 3 ? i + 1 : 3); end
    end
    clear_in();
    hs.PCSrcD = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      nvec++; if (hs.FlushCount !== 2'(i < 3 ? i + 1 : 3)) begin nerr++; $display("FAIL sat_flush%0d got %0d want %0d", i, hs.FlushCount, i < 3 ? i + 1 : 3); end
    end
  endtask
  initial begin
    RstN = 1'b0;
    clear_in();
    test_reset();
    test_forward();
    test_load_use();
    test_branch_load();
    test_stop_blocked_and_reset();
    test_halt();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/hazard_control.md
# hazard_control

Hazard and pipeline-control unit for the 5-stage MIPS32 core: drives the stall enables and synchronous flush strobes of the IF/ID and ID/EX pipeline registers, selects forwarding paths for the EXE ALU operands and the ID-stage branch comparator, and sequences the halt drain when a stop instruction is decoded. It sits beside the decode stage. It is the controlling end of every `Enable*`/`Rst*` pair consumed by the pipeline registers.

## Interface
- `CNT_W`, default 16: width of the saturating stall/flush performance counters.
- `CLK  in  1`: clock; all state updates on the rising edge.
- `RstN  in  1`: reset, asynchronous, active-low.
- `RsD, RtD  in  5`: source registers of the instruction in ID.
- `RsE, RtE  in  5`: source registers of the instruction in EXE.
- `WriteRegE, WriteRegM, WriteRegW  in  5`: destination registers in EXE/MEM/WB.
- `RegWriteE, RegWriteM, RegWriteW  in  1`: register-write flags per stage.
- `LoadE, MemtoRegM  in  1`: the EXE instruction is a load; the MEM instruction writes load data.
- `BranchD  in  1`: ID holds a branch that compares registers in ID.
- `PCSrcD  in  1`: branch or jump in ID is taken.
- `StopD  in  1`: ID holds the stop instruction.
- `EnableF, EnableD, EnableE  out  1`: PC, IF/ID and ID/EX register enables.
- `RstD, RstE  out  1`: synchronous flush of IF/ID and ID/EX.
- `ForwardAE, ForwardBE  out  2`: ALU operand source: 00 register file, 01 WB result, 10 MEM ALU result.
- `ForwardAD, ForwardBD  out  1`: branch comparator takes the MEM ALU result.
- `Halted  out  1`: the pipeline has fully drained after a stop.
- `StallCount, FlushCount  out  CNT_W`: saturating event counters.

## Operation
- **Register match.** A match `X(r)` requires that the stage's `RegWrite` is 1, its `WriteReg` is not 0, and its `WriteReg` equals `r`. Register 0 never matches.
- **EXE forwarding.**
  - `ForwardAE` is 10 if `M(RsE)`; else 01 if `W(RsE)`; else 00.
  - `ForwardBE` is the same using `RtE`.
  - MEM has priority over WB.
- **ID forwarding.** `ForwardAD` = `M(RsD)`, `ForwardBD` = `M(RtD)`. These ignore `MemtoRegM`; load data is handled by stalling.
- **Stall conditions.** `StallD` is 1 when either of the following holds:
  - `LoadE` and `E(RsD|RtD)`.
  - `BranchD` and either `E(RsD|RtD)`, or (`MemtoRegM` and `M(RsD|RtD)`).
- **Flush condition.** `FlushD` = `PCSrcD & ~StallD`. A stall masks the flush because the branch is not yet resolved.
- **FSM states:** RUN, DRAIN, HALTED. A 2-bit drain counter is used in DRAIN.
  - RUN:
    - `EnableF` = `EnableD` = `~StallD`; `EnableE` = 1.
    - `RstE` = `StallD` (one bubble per stall cycle).
    - `RstD` = `FlushD`.
    - If `StopD & ~StallD`: go to DRAIN and load the counter with 3.
    - If `StopD & StallD`: stay in RUN and retry next cycle.
  - DRAIN:
    - `EnableF` = `EnableD` = 0; `EnableE` = 1; `RstE` = 1; `RstD` = 0.
    - The counter decrements each cycle. On the cycle it reads 1, go to HALTED.
    - `StallD`, `PCSrcD` and `StopD` are ignored.
  - HALTED:
    - All enables 0; `RstD` = `RstE` = 0; `Halted` = 1.
    - Only reset exits this state.
- **Forwarding outputs** are computed identically in all states.
- **Counters.**
  - `StallCount` increments in every RUN cycle with `StallD` = 1.
  - `FlushCount` increments in every RUN cycle with `FlushD` = 1.
  - Both saturate at all-ones and never wrap.

## Timing
- Hazard, enable, flush and forward outputs are combinational from the current inputs and the FSM state, with zero latency. They are consumed at the next `CLK` edge by the pipeline registers.
- **Reset.** While `RstN` = 0, the outputs are forced regardless of inputs:
  - `EnableF` = `EnableD` = `EnableE` = 0, `RstD` = `RstE` = 1.
  - `Forward*` = 0, `Halted` = 0.
  - The counters are cleared asynchronously, and the FSM goes to RUN with the counter at 0.
  - Reset asserted mid-DRAIN or in HALTED returns to RUN immediately.
- **Stop timing.** The stop enters EXE on the edge that leaves RUN, then reaches MEM, then WB. There are 3 DRAIN cycles, and `Halted` rises in the 4th cycle after the stop was in ID.
- A load-use stall lasts exactly 1 cycle. A branch depending on an EXE load stalls 2 cycles: 1 for the EXE match, then 1 for the `MemtoRegM` match.
- A stall and a taken branch in the same cycle produce a stall only (`RstD` = 0).

## Test plan
- **Load-use stall.** `LoadE`=1, `RegWriteE`=1, `WriteRegE`=8, `RsD`=8 -> `EnableF`=`EnableD`=0, `RstE`=1 for 1 cycle; `StallCount` 0->1.
- **Forward priority.** `WriteRegM`=`WriteRegW`=5, both write, `RsE`=5 -> `ForwardAE`=10. With `WriteRegM`=0 -> 01. With register 0 in both stages -> 00.
- **Branch after load.** `BranchD`=1, `LoadE` to `$9`, `RtD`=9 -> 2 stall cycles; `PCSrcD`=1 throughout gives `RstD`=0 while stalled and `RstD`=1 in the third cycle; `FlushCount`=1.
- **Halt sequence.** `StopD`=1 with no stall -> DRAIN for 3 cycles with `RstE`=1 and `EnableF`=0; `Halted`=1 in the 4th cycle and stays 1 with inputs toggling.
- **Stop blocked by stall.** `StopD` together with a load-use match -> 1 stall cycle, then DRAIN begins.
- **Reset behaviour.** `RstN` pulsed low mid-DRAIN -> outputs take their reset values asynchronously, counters read 0; after release, RUN with all enables 1.
- **Counter saturation.** Force `StallCount` to 0xFFFE, apply 3 stall cycles -> reads 0xFFFF.
